// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Optional same-cycle write/issue bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, issue wins on a tie.
// Register 0 is never busy. Exports current and next-state busy vectors.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG),
    parameter int NWR  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic [NREG-1:0]   busy_q,
    output logic [NREG-1:0]   busy_d,
    output logic              busy_any
);

    logic clr;

    always_comb begin
        busy_d    = busy_q;
        busy_d[0] = 1'b0;
        clr       = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            clr = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
                    clr = 1'b1;
                end
            end
            // A new producer issuing this cycle outranks the retiring one.
            if (iss_en && (iss_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (clr) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            busy_any <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            busy_any <= |busy_d;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with hardwired zero register and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes and busy updates to reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 2,
    parameter int NWR  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                busy_any
);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy_q;
`ifdef REGFILE_BYPASS_EN
    logic [NREG-1:0] busy_d;
`else
    logic [NREG-1:0] busy_d_unused;
`endif

    logic [XLEN-1:0] rd_val [NRD];
    logic [NRD-1:0]  rd_bsy;

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW),
        .NWR  (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_q   (busy_q),
`ifdef REGFILE_BYPASS_EN
        .busy_d   (busy_d),
`else
        .busy_d   (busy_d_unused),
`endif
        .busy_any (busy_any)
    );

    // Ascending port order makes the highest-index writer win on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(ZERO_REG))) begin
                    mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_val[i] = mem[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            rd_bsy[i] = busy_d[rd_addr[i*AW +: AW]];
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
                    rd_val[i] = wr_data[j*XLEN +: XLEN];
                end
            end
`else
            rd_bsy[i] = busy_q[rd_addr[i*AW +: AW]];
`endif
            if (rd_addr[i*AW +: AW] == AW'(ZERO_REG)) begin
                rd_val[i] = '0;
                rd_bsy[i] = 1'b0;
            end
        end
    end

    // Read ports with rd_en low keep their last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (rd_en[i]) begin
                    rd_data[i*XLEN +: XLEN] <= rd_val[i];
                    rd_busy[i]              <= rd_bsy[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NRD=2, NWR=2): directed steps plus random traffic
// against an array-based reference model. Expectations follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                busy_any;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [XLEN-1:0] m_reg [NREG];
    logic [NREG-1:0] m_busy;
    logic [XLEN-1:0] exp_data [NRD];
    logic            exp_busy [NRD];
    logic [XLEN-1:0] exp_q [$];

    regfile_mp #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_any (busy_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) m_reg[r] = '0;
        m_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            exp_data[i] = '0;
            exp_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0;
        wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    task automatic drive_wr(input int port, input int addr, input logic [31:0] data);
        wr_en[port]              = 1'b1;
        wr_addr[port*AW +: AW]   = AW'(addr);
        wr_data[port*XLEN +: XLEN] = data;
    endtask

    task automatic drive_rd(input int port, input int addr);
        rd_en[port]            = 1'b1;
        rd_addr[port*AW +: AW] = AW'(addr);
    endtask

    task automatic drive_iss(input int addr);
        iss_en   = 1'b1;
        iss_addr = AW'(addr);
    endtask

    // Applies the current inputs for one clock (called at negedge) and checks every output.
    task automatic tick(input string tag);
        logic [XLEN-1:0] n_reg [NREG];
        logic [NREG-1:0] n_busy;
        int a;
        n_reg  = m_reg;
        n_busy = m_busy;
        for (int j = 0; j < NWR; j++) begin
            a = int'(wr_addr[j*AW +: AW]);
            if (wr_en[j] && a != 0) n_reg[a] = wr_data[j*XLEN +: XLEN];
            if (wr_en[j]) n_busy[a] = 1'b0;
        end
        if (iss_en && iss_addr != 0) n_busy[iss_addr] = 1'b1;
        for (int i = 0; i < NRD; i++) begin
            if (rd_en[i]) begin
                a = int'(rd_addr[i*AW +: AW]);
                exp_data[i] = BYPASS ? n_reg[a] : m_reg[a];
                exp_busy[i] = BYPASS ? n_busy[a] : m_busy[a];
            end
            exp_q.push_back(exp_data[i]);
        end
        m_reg  = n_reg;
        m_busy = n_busy;
        @(posedge clk);
        #1;
        for (int i = 0; i < NRD; i++) begin
            check($sformatf("%s.rd%0d_data", tag, i), rd_data[i*XLEN +: XLEN], exp_q.pop_front());
            check($sformatf("%s.rd%0d_busy", tag, i), 32'(rd_busy[i]), 32'(exp_busy[i]));
        end
        check($sformatf("%s.busy_any", tag), 32'(busy_any), 32'(|m_busy));
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset.rd_data", rd_data[31:0] | rd_data[63:32], 32'h0);
        check("reset.rd_busy", 32'(rd_busy), 32'h0);
        check("reset.busy_any", 32'(busy_any), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read on port 1, then hold
        drive_wr(0, 7, 32'hDEADBEEF);
        tick("wr_r7");
        drive_rd(1, 7);
        tick("rd_r7");
        check("basic.rd1", rd_data[63:32], 32'hDEADBEEF);
        tick("hold_r7");
        check("basic.hold", rd_data[63:32], 32'hDEADBEEF);

        // Same-cycle write/read of r4
        drive_wr(0, 4, 32'h01);
        tick("wr_r4");
        drive_wr(0, 4, 32'hAB);
        drive_rd(0, 4);
        tick("bypass_r4");
        check("bypass.r4", rd_data[31:0], BYPASS ? 32'hAB : 32'h01);

        // Zero register ignores writes and issues
        drive_wr(1, 0, 32'hFFFFFFFF);
        drive_iss(0);
        tick("wr_r0");
        drive_rd(0, 0);
        tick("rd_r0");
        check("zero.data", rd_data[31:0], 32'h0);
        check("zero.busy", 32'(rd_busy[0]), 32'h0);
        check("zero.busy_any", 32'(busy_any), 32'h0);

        // Write collision: higher port wins
        drive_wr(0, 3, 32'h11);
        drive_wr(1, 3, 32'h22);
        tick("collide_r3");
        drive_rd(1, 3);
        tick("rd_r3");
        check("collide.r3", rd_data[63:32], 32'h22);

        // Scoreboard set / tie / clear
        drive_iss(9);
        tick("iss_r9");
        check("sb.busy_any_set", 32'(busy_any), 32'h1);
        drive_rd(0, 9);
        tick("rd_busy_r9");
        check("sb.rd_busy_set", 32'(rd_busy[0]), 32'h1);
        drive_wr(0, 9, 32'h55);
        drive_iss(9);
        tick("wb_iss_r9");
        drive_rd(0, 9);
        tick("rd_r9_tie");
        check("sb.tie_busy", 32'(rd_busy[0]), 32'h1);
        drive_wr(1, 9, 32'h55);
        tick("wb_r9");
        drive_rd(0, 9);
        tick("rd_r9_clr");
        check("sb.clr_busy", 32'(rd_busy[0]), 32'h0);
        check("sb.clr_any", 32'(busy_any), 32'h0);
        check("sb.r9_data", rd_data[31:0], 32'h55);

        // Random traffic over a narrow address range to provoke collisions
        for (int n = 0; n < 250; n++) begin
            for (int p = 0; p < NWR; p++) begin
                if ($urandom_range(0, 1) == 1) drive_wr(p, $urandom_range(0, 7), $urandom);
            end
            for (int p = 0; p < NRD; p++) begin
                if ($urandom_range(0, 2) != 0) drive_rd(p, $urandom_range(0, 7));
            end
            if ($urandom_range(0, 2) == 0) drive_iss($urandom_range(0, 7));
            tick("rand");
        end

        // Asynchronous reset mid-cycle with state and traffic in flight
        drive_wr(0, 5, 32'h1234);
        drive_iss(5);
        tick("wr_iss_r5");
        drive_rd(0, 5);
        tick("rd_r5_pre");
        check("pre_reset.data", rd_data[31:0], 32'h1234);
        drive_wr(1, 5, 32'hBEEF);
        drive_iss(6);
        drive_rd(0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset.rd_data", rd_data[31:0] | rd_data[63:32], 32'h0);
        check("async_reset.rd_busy", 32'(rd_busy), 32'h0);
        check("async_reset.busy_any", 32'(busy_any), 32'h0);
        @(posedge clk);
        #1;
        check("reset_hold.busy_any", 32'(busy_any), 32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        drive_rd(0, 5);
        tick("rd_r5_post");
        check("post_reset.r5", rd_data[31:0], 32'h0);
        check("post_reset.busy", 32'(rd_busy[0]), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the CPU datapath.
- Successor to the single-write, two-read register file. Adds:
  - configurable width, depth and read/write port counts
  - async active-low reset of architectural state
  - hardwired zero register
  - write-port priority
  - a per-register busy scoreboard for in-flight producers
- Sits between decode (reads, issue) and writeback.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of registers; power of two, >= 2.
- AW, $clog2(NREG), address width; derived, do not override.
- NRD, 2, number of read ports, 1..4.
- NWR, 1, number of write ports, 1..2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rd_en  in  NRD  per-port read enable.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  registered read data; port i occupies bits [i*XLEN +: XLEN].
- rd_busy  out  NRD  registered busy flag of the addressed register.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_en  in  1  issue strobe: marks iss_addr busy.
- iss_addr  in  AW  destination register of the issuing instruction.
- busy_any  out  1  OR of all busy bits, registered.

Behaviour:
- Reset (rst_n low, async): all NREG registers = 0; all busy bits = 0; rd_data = 0; rd_busy = 0; busy_any = 0. State is held while rst_n is low. On deassertion, normal operation starts at the next posedge.
- Reset mid-operation: in-flight writes and issues in that cycle are discarded. Nothing is replayed.
- Register 0: always reads 0 and is never busy. Writes and issues to address 0 are ignored.
- Write: at posedge, if wr_en[j] and wr_addr[j] != 0, then reg[wr_addr[j]] <= wr_data[j]. No X-filtering of data.
- Write collision: two ports write the same address in one cycle → the higher port index wins.
- Busy update per posedge, per register r:
  - set if iss_en && iss_addr == r && r != 0
  - else cleared if any wr_en[j] && wr_addr[j] == r
  - else held
  - Issue beats writeback on the same address in the same cycle; busy stays 1 (new producer).
- Read: 1-cycle latency.
  - rd_en[i] high at posedge N → rd_data[i] and rd_busy[i] valid after posedge N.
  - rd_en[i] low → rd_data[i] and rd_busy[i] hold their previous values.
- Out-of-range address (NREG below 2^AW cannot occur; AW is derived): no special case.
- busy_any: registered OR of the next-state busy vector.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read whose address matches a same-cycle write returns the new data (highest-index matching write port).
  - rd_busy returns the next-state busy bit, including the same-cycle issue or clear.
  - Address 0 still returns 0 and not busy.
- Undefined:
  - A read returns the pre-write register contents.
  - rd_busy returns the current-state busy bit.
  - Decode must insert one bubble for write-then-read on the same register.

Decomposition:
- Package regfile_pkg holds:
  - localparam XLEN_DEF = 32 and NREG_DEF = 32
  - typedef reg_addr_t (logic [4:0]) and reg_data_t (logic [31:0])
  - localparam reg_addr_t ZERO_REG = '0
- Sub-module regfile_scoreboard (NREG, AW, NWR) owns:
  - the busy-bit vector
  - set/clear priority
  - busy_any
- It exports the current and next busy vectors to the top for rd_busy selection.
- The top holds the storage array, write logic and read/bypass muxes.

Test Plan:
- Reset: drive rst_n low mid-cycle with reg[5] = 0x1234 and busy[5] = 1 → immediately rd_data = 0, rd_busy = 0, busy_any = 0. After release, a read of addr 5 gives 0.
- Basic write/read: write 0xDEADBEEF to r7, then read r7 on port 1 the next cycle → rd_data[1] = 0xDEADBEEF one cycle after rd_en. rd_en low afterwards → value held.
- Zero register: write 0xFFFFFFFF to r0 and issue r0 → read r0 gives 0, rd_busy = 0, busy_any unchanged.
- Collision (NWR = 2): same cycle, port0 writes r3 = 0x11 and port1 writes r3 = 0x22 → r3 reads 0x22.
- Scoreboard: issue r9 → busy_any = 1 and a read of r9 shows rd_busy = 1. Writeback r9 = 0x55 plus issue r9 in the same cycle → busy stays 1. Writeback only → busy 0 and busy_any = 0.
- Bypass: same cycle, write r4 = 0xAB and read r4 (r4 previously 0x01) → 0xAB with REGFILE_BYPASS_EN defined, 0x01 without.
